// File: rtl/output_div_scheduler_pkg.sv
// Shared widths and the channel tag that travels alongside the divider pipeline.
package output_div_scheduler_pkg;

  localparam int DIV_DIVIDEND_W = 28;
  localparam int DIV_DIVISOR_W  = 20;
  localparam int DIV_Q_W        = 8;
  localparam int TAG_CHAN_W     = 8;

  typedef struct packed {
    logic                  valid;
    logic                  zero;
    logic [TAG_CHAN_W-1:0] chan;
  } div_tag_t;

endpackage

// File: rtl/output_div_scheduler_sync_fifo.sv
// Synchronous FIFO with full/empty/count flags; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/output_div_scheduler.sv
// Round-robin sharing of one pipelined divider between N_CH channels; results are
// re-tagged with their channel and buffered, with credits reserving a FIFO slot per issue.
module output_div_scheduler
  import output_div_scheduler_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int DIV_LATENCY = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [N_CH-1:0]                req_valid,
  input  logic [N_CH*DIV_DIVIDEND_W-1:0] req_sum,
  input  logic [N_CH*DIV_DIVISOR_W-1:0]  req_count,
  output logic [N_CH-1:0]                req_ready,
  output logic                           div_start,
  output logic [DIV_DIVIDEND_W-1:0]      div_dividend,
  output logic [DIV_DIVISOR_W-1:0]       div_divisor,
  input  logic                           div_start_out,
  input  logic [DIV_Q_W-1:0]             div_q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DIV_Q_W-1:0]             out_data,
  output logic [CH_W-1:0]                out_chan,
  output logic                           busy,
  output logic                           err_align
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

  logic [CRED_W-1:0]         credits;
  logic [CH_W-1:0]           rr_ptr;
  logic [CH_W-1:0]           grant_idx;
  logic [N_CH-1:0]           grant_vec;
  logic                      found;
  logic                      issue;
  int                        cand;
  logic [DIV_DIVIDEND_W-1:0] sel_sum;
  logic [DIV_DIVISOR_W-1:0]  sel_count;
  logic                      issue_zero;
  logic [CH_W-1:0]           issue_chan;
  div_tag_t                  tag_pipe [DIV_LATENCY];
  div_tag_t                  tail;
  logic                      tag_busy;
  logic                      push;
  logic                      pop;
  logic [DIV_Q_W-1:0]        push_q;
  logic [CH_W-1:0]           push_chan;
  logic [DIV_Q_W+CH_W-1:0]   fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CRED_W-1:0]         fifo_count;

  // Search starts at the round-robin pointer and wraps; no grant without a credit.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = (int'(rr_ptr) + i) % N_CH;
      if (!found && req_valid[cand]) begin
        found           = 1'b1;
        grant_idx       = CH_W'(cand);
        grant_vec[cand] = 1'b1;
      end
    end
    issue     = found && (credits != '0);
    req_ready = issue ? grant_vec : '0;
  end

  assign sel_sum   = req_sum[int'(grant_idx)*DIV_DIVIDEND_W +: DIV_DIVIDEND_W];
  assign sel_count = req_count[int'(grant_idx)*DIV_DIVISOR_W +: DIV_DIVISOR_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      issue_zero   <= 1'b0;
      issue_chan   <= '0;
      rr_ptr       <= '0;
    end else begin
      div_start <= issue;
      if (issue) begin
        div_dividend <= sel_sum;
        div_divisor  <= (sel_count == '0) ? DIV_DIVISOR_W'(1) : sel_count;
        issue_zero   <= (sel_count == '0);
        issue_chan   <= grant_idx;
        rr_ptr       <= CH_W'((int'(grant_idx) + 1) % N_CH);
      end
    end
  end

  // Stage 0 captures on the edge where the divider samples div_start, so the tail lines up with div_start_out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DIV_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: div_start, zero: issue_zero, chan: TAG_CHAN_W'(issue_chan)};
      for (int k = 1; k < DIV_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    tag_busy = 1'b0;
    for (int k = 0; k < DIV_LATENCY; k++) tag_busy = tag_busy | tag_pipe[k].valid;
  end

  assign tail      = tag_pipe[DIV_LATENCY-1];
  assign push      = div_start_out;
  assign push_q    = (tail.valid && tail.zero) ? {DIV_Q_W{1'b0}} : div_q;
  assign push_chan = tail.valid ? tail.chan[CH_W-1:0] : {CH_W{1'b0}};
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (DIV_Q_W + CH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_q, push_chan}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DIV_Q_W+CH_W-1:CH_W];
  assign out_chan  = fifo_head[CH_W-1:0];
  assign busy      = div_start || tag_busy || (fifo_count != '0);

  // Credits saturate at FIFO_DEPTH so popping an unsolicited entry cannot mint a credit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits   <= CRED_W'(FIFO_DEPTH);
      err_align <= 1'b0;
    end else begin
      if (issue && !pop) credits <= credits - 1'b1;
      else if (pop && !issue && credits != CRED_W'(FIFO_DEPTH)) credits <= credits + 1'b1;
      if ((div_start_out != tail.valid) || (push && fifo_full && !pop)) err_align <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_div_scheduler.sv
// Directed bench with a queue-based model of issue order, credits, latency and error flag.
module tb_output_div_scheduler;
  import output_div_scheduler_pkg::*;

  localparam int N_CH        = 4;
  localparam int CH_W        = 2;
  localparam int DIV_LATENCY = 8;
  localparam int FIFO_DEPTH  = 4;

  logic                           clock;
  logic                           reset_n;
  logic [N_CH-1:0]                req_valid;
  logic [N_CH*DIV_DIVIDEND_W-1:0] req_sum;
  logic [N_CH*DIV_DIVISOR_W-1:0]  req_count;
  logic [N_CH-1:0]                req_ready;
  logic                           div_start;
  logic [DIV_DIVIDEND_W-1:0]      div_dividend;
  logic [DIV_DIVISOR_W-1:0]       div_divisor;
  logic                           div_start_out;
  logic [DIV_Q_W-1:0]             div_q;
  logic                           out_valid;
  logic                           out_ready;
  logic [DIV_Q_W-1:0]             out_data;
  logic [CH_W-1:0]                out_chan;
  logic                           busy;
  logic                           err_align;

  output_div_scheduler #(
    .N_CH(N_CH), .CH_W(CH_W), .DIV_LATENCY(DIV_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_sum(req_sum),
    .req_count(req_count), .req_ready(req_ready), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start_out(div_start_out),
    .div_q(div_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .busy(busy), .err_align(err_align)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit inject = 1'b0;

  int               rem   [N_CH];
  logic [27:0]      sum_v [N_CH];
  logic [19:0]      cnt_v [N_CH];
  logic [N_CH-1:0]  hs_dut;

  typedef struct { logic [7:0] q; logic [CH_W-1:0] chan; bit spur; int rdy; } exp_t;
  typedef struct { int chan; int cyc; } grant_t;
  exp_t   exp_q[$];
  grant_t grant_log[$];

  int              rr_m;
  bit              exp_start;
  logic [27:0]     exp_dvd;
  logic [19:0]     exp_dvs;
  bit              err_m;
  logic [N_CH-1:0] eg;
  int              egi;
  int              egc;
  bit              got;
  bit              exp_ov;

  // Divider stand-in: fixed latency, quotient truncated to 8 bits, shares reset_n.
  logic       dv_v [DIV_LATENCY];
  logic [7:0] dv_q [DIV_LATENCY];
  logic [7:0] q_calc;
  assign q_calc = (div_divisor == '0) ? 8'hFF : 8'(div_dividend / 28'(div_divisor));

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DIV_LATENCY; k++) begin dv_v[k] <= 1'b0; dv_q[k] <= 8'h00; end
    end else begin
      dv_v[0] <= div_start;
      dv_q[0] <= q_calc;
      for (int k = 1; k < DIV_LATENCY; k++) begin dv_v[k] <= dv_v[k-1]; dv_q[k] <= dv_q[k-1]; end
    end
  end
  assign div_start_out = dv_v[DIV_LATENCY-1] | inject;
  assign div_q         = inject ? 8'hA5 : dv_q[DIV_LATENCY-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < N_CH; c++) begin
      req_valid[c]           = (rem[c] > 0);
      req_sum[c*28 +: 28]    = sum_v[c];
      req_count[c*20 +: 20]  = cnt_v[c];
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] mask, input int n,
                               input logic [27:0] sum, input logic [19:0] cnt);
    @(posedge clock); #2;
    for (int c = 0; c < N_CH; c++) begin
      if (mask[c]) begin rem[c] = n; sum_v[c] = sum; cnt_v[c] = cnt; end
    end
    refresh();
  endtask

  function automatic int credits_model();
    int n = 0;
    foreach (exp_q[k]) if (!exp_q[k].spur) n++;
    return FIFO_DEPTH - n;
  endfunction

  // Channels: a consumed pair is replaced by the next one with a different sum.
  always @(posedge clock) begin
    #1;
    for (int c = 0; c < N_CH; c++) begin
      if (hs_dut[c] && rem[c] > 0) begin
        rem[c]   = rem[c] - 1;
        sum_v[c] = sum_v[c] + 28'(1237 * (c + 1));
      end
    end
    refresh();
  end

  // Model: one outstanding result per accepted request, popped in issue order.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      exp_q.delete();
      grant_log.delete();
      rr_m      = 0;
      exp_start = 1'b0;
      err_m     = 1'b0;
      hs_dut    = '0;
    end else begin
      eg  = '0;
      egi = 0;
      got = 1'b0;
      if (credits_model() > 0) begin
        for (int i = 0; i < N_CH; i++) begin
          egc = (rr_m + i) % N_CH;
          if (!got && req_valid[egc]) begin got = 1'b1; egi = egc; eg[egc] = 1'b1; end
        end
      end
      exp_ov = (exp_q.size() != 0) && (cyc >= exp_q[0].rdy);
      checkOutput("req_ready", req_ready, eg);
      checkOutput("div_start", div_start, exp_start);
      if (exp_start) begin
        checkOutput("div_dividend", div_dividend, exp_dvd);
        checkOutput("div_divisor", div_divisor, exp_dvs);
      end
      checkOutput("busy", busy, exp_q.size() != 0);
      checkOutput("err_align", err_align, err_m);
      checkOutput("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        checkOutput("out_data", out_data, exp_q[0].q);
        checkOutput("out_chan", out_chan, exp_q[0].chan);
      end
      hs_dut    = req_valid & req_ready;
      exp_start = 1'b0;
      if (got) begin
        exp_q.push_back('{q: (cnt_v[egi] == 0) ? 8'h00 : 8'(sum_v[egi] / 28'(cnt_v[egi])),
                          chan: CH_W'(egi), spur: 1'b0, rdy: cyc + DIV_LATENCY + 2});
        grant_log.push_back('{chan: egi, cyc: cyc});
        rr_m      = (egi + 1) % N_CH;
        exp_start = 1'b1;
        exp_dvd   = sum_v[egi];
        exp_dvs   = (cnt_v[egi] == 0) ? 20'd1 : cnt_v[egi];
      end
      if (inject) begin
        exp_q.push_back('{q: 8'hA5, chan: '0, spur: 1'b1, rdy: cyc + 1});
        err_m = 1'b1;
      end
      if (exp_ov && out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_div_start", div_start, 0);
    checkOutput("rst_div_dividend", div_dividend, 0);
    checkOutput("rst_div_divisor", div_divisor, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_chan", out_chan, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_align", err_align, 0);
  endtask

  task automatic doReset();
    @(posedge clock); #3;
    reset_n = 1'b0;
    inject  = 1'b0;
    for (int c = 0; c < N_CH; c++) rem[c] = 0;
    refresh();
    #1 checkResetValues();
    @(negedge clock);
    @(negedge clock);
    @(posedge clock); #3;
    reset_n = 1'b1;
  endtask

  task automatic waitGrant(input int n);
    int k = 0;
    while (grant_log.size() < n && k < 60) begin @(negedge clock); #1; k++; end
    if (grant_log.size() < n) checkOutput("grant_timeout", grant_log.size(), n);
  endtask

  task automatic waitOutValid();
    int k = 0;
    while (!out_valid && k < 60) begin @(negedge clock); #1; k++; end
    if (!out_valid) checkOutput("out_valid_timeout", out_valid, 1);
  endtask

  int g_cyc;

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    hs_dut    = '0;
    for (int c = 0; c < N_CH; c++) begin rem[c] = 0; sum_v[c] = '0; cnt_v[c] = '0; end
    refresh();
    #1 checkResetValues();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    $display("[TB] single request on channel 2");
    out_ready = 1'b1;
    applyStimulus(4'b0100, 1, 28'd1000, 20'd10);
    waitGrant(1);
    g_cyc = (grant_log.size() > 0) ? grant_log[0].cyc : cyc;
    @(negedge clock); #1;
    checkOutput("t1_div_start", div_start, 1);
    checkOutput("t1_dividend", div_dividend, 1000);
    checkOutput("t1_divisor", div_divisor, 10);
    waitOutValid();
    checkOutput("t1_latency", cyc - g_cyc, DIV_LATENCY + 2);
    checkOutput("t1_out_data", out_data, 100);
    checkOutput("t1_out_chan", out_chan, 2);

    $display("[TB] all channels valid, round-robin order");
    doReset();
    out_ready = 1'b1;
    applyStimulus(4'b1111, 100, 28'd5000, 20'd7);
    waitGrant(6);
    if (grant_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) checkOutput($sformatf("t2_grant%0d", k), grant_log[k].chan, k % 4);
      for (int k = 1; k < 4; k++) checkOutput($sformatf("t2_cycle%0d", k), grant_log[k].cyc - grant_log[0].cyc, k);
    end

    $display("[TB] credit exhaustion with output stalled");
    doReset();
    out_ready = 1'b0;
    applyStimulus(4'b0001, 10, 28'd300, 20'd3);
    repeat (25) @(negedge clock);
    #1;
    checkOutput("t3_issued", grant_log.size(), 4);
    checkOutput("t3_req_ready", req_ready, 0);
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    repeat (15) @(negedge clock);
    #1;
    checkOutput("t3_issued_after_pop", grant_log.size(), 5);

    $display("[TB] zero divisor on channel 1");
    doReset();
    out_ready = 1'b1;
    applyStimulus(4'b0010, 1, 28'd500, 20'd0);
    waitGrant(1);
    @(negedge clock); #1;
    checkOutput("t4_divisor", div_divisor, 1);
    waitOutValid();
    checkOutput("t4_out_data", out_data, 0);
    checkOutput("t4_out_chan", out_chan, 1);
    checkOutput("t4_err_align", err_align, 0);

    $display("[TB] spurious divider strobe");
    doReset();
    out_ready = 1'b1;
    @(posedge clock); #2 inject = 1'b1;
    @(posedge clock); #2 inject = 1'b0;
    repeat (4) @(negedge clock);
    #1 checkOutput("t5_err_set", err_align, 1);
    repeat (10) @(negedge clock);
    #1 checkOutput("t5_err_sticky", err_align, 1);
    doReset();
    @(negedge clock); #1;
    checkOutput("t5_err_cleared", err_align, 0);

    $display("[TB] reset with work in flight");
    out_ready = 1'b0;
    applyStimulus(4'b0100, 2, 28'd2000, 20'd9);
    repeat (14) @(negedge clock);
    applyStimulus(4'b1000, 2, 28'd800, 20'd5);
    repeat (4) @(negedge clock);
    #1 checkOutput("t6_prefill", grant_log.size(), 4);
    checkOutput("t6_out_valid_before", out_valid, 1);
    doReset();
    out_ready = 1'b1;
    repeat (20) @(negedge clock);
    #1 checkOutput("t6_no_stale", out_valid, 0);
    out_ready = 1'b0;
    applyStimulus(4'b0001, 6, 28'd100, 20'd1);
    repeat (20) @(negedge clock);
    #1 checkOutput("t6_credits_restored", grant_log.size(), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
